// File: rtl/ram_buffer_pkg.sv
// Shared types and default sizing for the RAM buffer allocation front-end.
package ram_buffer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_FLUSH  = 2'd2
    } buf_state_e;

    localparam int unsigned ENT_NUM_DEF = 8;
    localparam int unsigned DATA_W_DEF  = 128;
    localparam int unsigned ADDR_W_DEF  = 8;
    localparam int unsigned BYTE_IDX_W  = 4;

endpackage

// File: rtl/ram_buffer_alloc_rr_first_set.sv
// Round-robin first-set finder: first set bit of vec at or after ptr, wrapping.
module rr_first_set #(
    parameter int unsigned N  = 8,
    parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  vec,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] idx,
    output logic          found
);

    logic [IW-1:0] cand;

    // N is a power of two, so ptr + i wraps modulo N for free.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = ptr + IW'(i);
            if (!found && vec[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ram_buffer_alloc.sv
// Allocation front-end: allocates free buffer entries for read-return beats,
// bumps reference counts on address hits, routes releases and sequences flush.
module ram_buffer_alloc
    import ram_buffer_pkg::*;
#(
    parameter int unsigned ENT_NUM = ENT_NUM_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned IDX_W   = $clog2(ENT_NUM)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_vld,
    output logic                  req_rdy,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_data,
    input  logic [BYTE_IDX_W-1:0] req_start_byte,
    input  logic [BYTE_IDX_W-1:0] req_end_byte,
    input  logic [ENT_NUM-1:0]    ent_free,
    input  logic [ENT_NUM-1:0]    ent_addr_match,
    output logic [ENT_NUM-1:0]    alloc_en,
    output logic [DATA_W-1:0]     alloc_data,
    output logic [ADDR_W-1:0]     alloc_addr,
    output logic [BYTE_IDX_W-1:0] buff_start_byte,
    output logic [BYTE_IDX_W-1:0] buff_end_byte,
    output logic [ENT_NUM-1:0]    ent_cnt_inc,
    input  logic                  rel_vld,
    input  logic [IDX_W-1:0]      rel_idx,
    output logic [ENT_NUM-1:0]    ent_cnt_dec,
    input  logic                  flush_req,
    output logic                  flush_done,
    output logic [IDX_W:0]        occ_cnt,
    output logic                  full
);

    buf_state_e            state_q, state_d;
    logic [ENT_NUM-1:0]    alloc_en_q, alloc_en_d;
    logic [ENT_NUM-1:0]    inc_q, inc_d;
    logic [ENT_NUM-1:0]    dec_q, dec_d;
    logic [ADDR_W-1:0]     alloc_addr_q, alloc_addr_d;
    logic [DATA_W-1:0]     alloc_data_q, alloc_data_d;
    logic [BYTE_IDX_W-1:0] sb_q, sb_d;
    logic [BYTE_IDX_W-1:0] eb_q, eb_d;
    logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [IDX_W:0]        occ_q, occ_d;
    logic                  flush_done_q, flush_done_d;

    logic [ENT_NUM-1:0]    eff_free;
    logic                  inflight_hit;
    logic                  match_found;
    logic [IDX_W-1:0]      match_idx;
    logic                  free_found;
    logic [IDX_W-1:0]      free_idx;
    logic                  hit;
    logic                  accept;
    logic                  pending;

    // The entry allocated last cycle still reports free; mask it out.
    assign eff_free     = ent_free & ~alloc_en_q;
    assign full         = ~|eff_free;
    assign inflight_hit = (|alloc_en_q) && (alloc_addr_q == req_addr);
    assign hit          = inflight_hit | match_found;
    assign req_rdy      = (state_q == ST_ACTIVE) && !flush_req && (hit || !full);
    assign accept       = req_vld & req_rdy;
    assign pending      = |{alloc_en_q, inc_q, dec_q};

    rr_first_set #(
        .N  (ENT_NUM),
        .IW (IDX_W)
    ) u_match_find (
        .vec   (ent_addr_match),
        .ptr   ('0),
        .idx   (match_idx),
        .found (match_found)
    );

    rr_first_set #(
        .N  (ENT_NUM),
        .IW (IDX_W)
    ) u_free_find (
        .vec   (eff_free),
        .ptr   (rr_ptr_q),
        .idx   (free_idx),
        .found (free_found)
    );

    always_comb begin
        state_d      = state_q;
        alloc_en_d   = '0;
        inc_d        = '0;
        dec_d        = '0;
        alloc_addr_d = alloc_addr_q;
        alloc_data_d = alloc_data_q;
        sb_d         = sb_q;
        eb_d         = eb_q;
        rr_ptr_d     = rr_ptr_q;
        flush_done_d = 1'b0;
        occ_d        = (IDX_W+1)'(ENT_NUM - $countones(eff_free));

        if (rel_vld) begin
            dec_d[rel_idx] = 1'b1;
        end

        if (accept) begin
            if (inflight_hit) begin
                inc_d = alloc_en_q;
            end else if (match_found) begin
                inc_d[match_idx] = 1'b1;
            end else if (free_found) begin
                alloc_en_d[free_idx] = 1'b1;
                alloc_addr_d         = req_addr;
                alloc_data_d         = req_data;
                sb_d                 = req_start_byte;
                eb_d                 = req_end_byte;
                rr_ptr_d             = free_idx + 1'b1;
            end
        end

        case (state_q)
            ST_IDLE:   state_d = ST_ACTIVE;
            ST_ACTIVE: if (flush_req) state_d = ST_FLUSH;
            ST_FLUSH: begin
                if ((&ent_free) && !pending) begin
                    state_d      = ST_IDLE;
                    flush_done_d = 1'b1;
                end
            end
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            alloc_en_q   <= '0;
            inc_q        <= '0;
            dec_q        <= '0;
            alloc_addr_q <= '0;
            alloc_data_q <= '0;
            sb_q         <= '0;
            eb_q         <= '0;
            rr_ptr_q     <= '0;
            occ_q        <= '0;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            alloc_en_q   <= alloc_en_d;
            inc_q        <= inc_d;
            dec_q        <= dec_d;
            alloc_addr_q <= alloc_addr_d;
            alloc_data_q <= alloc_data_d;
            sb_q         <= sb_d;
            eb_q         <= eb_d;
            rr_ptr_q     <= rr_ptr_d;
            occ_q        <= occ_d;
            flush_done_q <= flush_done_d;
        end
    end

    assign alloc_en        = alloc_en_q;
    assign ent_cnt_inc     = inc_q;
    assign ent_cnt_dec     = dec_q;
    assign alloc_addr      = alloc_addr_q;
    assign alloc_data      = alloc_data_q;
    assign buff_start_byte = sb_q;
    assign buff_end_byte   = eb_q;
    assign occ_cnt         = occ_q;
    assign flush_done      = flush_done_q;

endmodule

// File: tb/tb_ram_buffer_alloc.sv
// Bench for ram_buffer_alloc: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model.
module tb_ram_buffer_alloc;

    localparam int ENT = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_vld;
    logic         req_rdy;
    logic [7:0]   req_addr;
    logic [127:0] req_data;
    logic [3:0]   req_start_byte, req_end_byte;
    logic [7:0]   ent_free, ent_addr_match;
    logic [7:0]   alloc_en;
    logic [127:0] alloc_data;
    logic [7:0]   alloc_addr;
    logic [3:0]   buff_start_byte, buff_end_byte;
    logic [7:0]   ent_cnt_inc;
    logic         rel_vld;
    logic [2:0]   rel_idx;
    logic [7:0]   ent_cnt_dec;
    logic         flush_req;
    logic         flush_done;
    logic [3:0]   occ_cnt;
    logic         full;

    int n_pass = 0;
    int n_chk  = 0;

    ram_buffer_alloc #(
        .ENT_NUM (8),
        .DATA_W  (128),
        .ADDR_W  (8)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_vld         (req_vld),
        .req_rdy         (req_rdy),
        .req_addr        (req_addr),
        .req_data        (req_data),
        .req_start_byte  (req_start_byte),
        .req_end_byte    (req_end_byte),
        .ent_free        (ent_free),
        .ent_addr_match  (ent_addr_match),
        .alloc_en        (alloc_en),
        .alloc_data      (alloc_data),
        .alloc_addr      (alloc_addr),
        .buff_start_byte (buff_start_byte),
        .buff_end_byte   (buff_end_byte),
        .ent_cnt_inc     (ent_cnt_inc),
        .rel_vld         (rel_vld),
        .rel_idx         (rel_idx),
        .ent_cnt_dec     (ent_cnt_dec),
        .flush_req       (flush_req),
        .flush_done      (flush_done),
        .occ_cnt         (occ_cnt),
        .full            (full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural model ----------------
    int           m_mode;      // 0 idle, 1 active, 2 flush
    int           m_ptr;
    logic [7:0]   m_alloc, m_inc, m_dec;
    logic [7:0]   m_addr;
    logic [127:0] m_data;
    logic [3:0]   m_sb, m_eb;
    int           m_occ;
    logic         m_done;

    task automatic model_reset();
        m_mode = 0; m_ptr = 0;
        m_alloc = '0; m_inc = '0; m_dec = '0;
        m_addr = '0; m_data = '0; m_sb = '0; m_eb = '0;
        m_occ = 0; m_done = 1'b0;
    endtask

    initial begin : model_compare
        logic [7:0] eff, n_alloc, n_inc;
        logic       e_full, e_hit, e_rdy, pend, done;
        model_reset();
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                model_reset();
                chk("rst_req_rdy", req_rdy, 0);
                chk("rst_alloc_en", alloc_en, 0);
                chk("rst_inc", ent_cnt_inc, 0);
                chk("rst_dec", ent_cnt_dec, 0);
                chk("rst_occ", occ_cnt, 0);
                chk("rst_flush_done", flush_done, 0);
                chk("rst_alloc_addr", alloc_addr, 0);
            end else begin
                eff    = ent_free & ~m_alloc;
                e_full = (eff == 0);
                e_hit  = (ent_addr_match != 0) || (m_alloc != 0 && m_addr == req_addr);
                e_rdy  = (m_mode == 1) && !flush_req && (e_hit || !e_full);

                chk("m_req_rdy", req_rdy, e_rdy);
                chk("m_full", full, e_full);
                chk("m_alloc_en", alloc_en, m_alloc);
                chk("m_inc", ent_cnt_inc, m_inc);
                chk("m_dec", ent_cnt_dec, m_dec);
                chk("m_flush_done", flush_done, m_done);
                chk("m_occ", occ_cnt, m_occ);
                chk("m_alloc_addr", alloc_addr, m_addr);
                chk("m_alloc_data", alloc_data, m_data);
                chk("m_start_byte", buff_start_byte, m_sb);
                chk("m_end_byte", buff_end_byte, m_eb);

                pend    = (m_alloc | m_inc | m_dec) != 0;
                n_alloc = '0;
                n_inc   = '0;
                if (req_vld && e_rdy) begin
                    if (m_alloc != 0 && m_addr == req_addr) begin
                        n_inc = m_alloc;
                    end else if (ent_addr_match != 0) begin
                        for (int i = 0; i < ENT; i++) begin
                            if (ent_addr_match[i]) begin n_inc = 8'(1 << i); break; end
                        end
                    end else begin
                        for (int k = 0; k < ENT; k++) begin
                            int j;
                            j = (m_ptr + k) % ENT;
                            if (eff[j]) begin
                                n_alloc = 8'(1 << j);
                                m_ptr   = (j + 1) % ENT;
                                m_addr  = req_addr;
                                m_data  = req_data;
                                m_sb    = req_start_byte;
                                m_eb    = req_end_byte;
                                break;
                            end
                        end
                    end
                end
                m_dec = rel_vld ? 8'(1 << rel_idx) : 8'h00;
                m_occ = ENT - $countones(eff);
                done  = 1'b0;
                if (m_mode == 0) m_mode = 1;
                else if (m_mode == 1) begin
                    if (flush_req) m_mode = 2;
                end else if (ent_free == 8'hFF && !pend) begin
                    m_mode = 0;
                    done   = 1'b1;
                end
                m_done  = done;
                m_alloc = n_alloc;
                m_inc   = n_inc;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        int flush_cnt;
        rst_n = 1'b0; req_vld = 1'b0; req_addr = '0; req_data = '0;
        req_start_byte = '0; req_end_byte = '0; ent_free = 8'hFF;
        ent_addr_match = '0; rel_vld = 1'b0; rel_idx = '0; flush_req = 1'b0;

        repeat (3) @(posedge clk);
        drive_edge();
        rst_n = 1'b1;
        @(negedge clk); chk("idle_req_rdy", req_rdy, 0);

        // first allocation lands on entry 0
        drive_edge();
        req_vld = 1'b1; req_addr = 8'h10; req_data = {4{$urandom()}};
        req_start_byte = 4'd2; req_end_byte = 4'd9;
        @(negedge clk); chk("d1_req_rdy", req_rdy, 1);
        drive_edge();
        req_vld = 1'b0;
        @(negedge clk);
        chk("d1_alloc_en", alloc_en, 8'h01);
        chk("d1_alloc_addr", alloc_addr, 8'h10);
        chk("d1_start_byte", buff_start_byte, 4'd2);
        chk("d1_end_byte", buff_end_byte, 4'd9);

        // same address twice: allocation then increment
        drive_edge();
        ent_free = 8'hFE; req_vld = 1'b1; req_addr = 8'h20;
        drive_edge();
        @(negedge clk);
        chk("d2_alloc_en", alloc_en, 8'h02);
        chk("d2_inc_none", ent_cnt_inc, 8'h00);
        drive_edge();
        req_vld = 1'b0; ent_free = 8'hFC;
        @(negedge clk);
        chk("d2_inc", ent_cnt_inc, 8'h02);
        chk("d2_no_realloc", alloc_en, 8'h00);

        // full: miss stalls, hit goes through
        drive_edge();
        ent_free = 8'h00; req_vld = 1'b1; req_addr = 8'h55;
        @(negedge clk);
        chk("d3_full_rdy", req_rdy, 0);
        chk("d3_full", full, 1);
        drive_edge();
        req_addr = 8'h66; ent_addr_match = 8'h04;
        @(negedge clk); chk("d3_hit_rdy", req_rdy, 1);
        drive_edge();
        req_vld = 1'b0; ent_addr_match = 8'h00;
        @(negedge clk);
        chk("d3_inc", ent_cnt_inc, 8'h04);
        chk("d3_occ", occ_cnt, 4'd8);

        // walk rr_ptr to 7, then wrap past the masked entry
        drive_edge();
        ent_free = 8'h40; req_vld = 1'b1; req_addr = 8'h61;
        drive_edge();
        req_vld = 1'b0;
        @(negedge clk); chk("d4_alloc6", alloc_en, 8'h40);
        drive_edge();
        ent_free = 8'h81; req_vld = 1'b1; req_addr = 8'h71;
        drive_edge();
        req_addr = 8'h72;
        @(negedge clk); chk("d4_alloc7", alloc_en, 8'h80);
        drive_edge();
        req_vld = 1'b0;
        @(negedge clk);
        chk("d4_wrap_alloc0", alloc_en, 8'h01);
        chk("d4_wrap_addr", alloc_addr, 8'h72);

        // increment and decrement of the same entry together
        drive_edge();
        ent_free = 8'h7E; req_vld = 1'b1; req_addr = 8'h33; ent_addr_match = 8'h08;
        rel_vld = 1'b1; rel_idx = 3'd3;
        drive_edge();
        req_vld = 1'b0; ent_addr_match = 8'h00; rel_vld = 1'b0;
        @(negedge clk);
        chk("d5_inc", ent_cnt_inc, 8'h08);
        chk("d5_dec", ent_cnt_dec, 8'h08);

        // flush with two busy entries, releases keep flowing
        drive_edge();
        ent_free = 8'hF3; flush_req = 1'b1;
        @(negedge clk); chk("d6_flush_rdy", req_rdy, 0);
        drive_edge();
        rel_vld = 1'b1; rel_idx = 3'd2;
        drive_edge();
        rel_idx = 3'd3;
        drive_edge();
        rel_vld = 1'b0;
        @(negedge clk); chk("d6_rel_dec", ent_cnt_dec, 8'h08);
        drive_edge();
        flush_req = 1'b0;
        @(negedge clk);
        chk("d6_still_flush_rdy", req_rdy, 0);
        chk("d6_no_done_yet", flush_done, 0);
        drive_edge();
        ent_free = 8'hFF;
        @(negedge clk); chk("d6_done_wait", flush_done, 0);
        drive_edge();
        @(negedge clk);
        chk("d6_flush_done", flush_done, 1);
        chk("d6_idle_rdy", req_rdy, 0);
        drive_edge();
        @(negedge clk);
        chk("d6_done_clear", flush_done, 0);
        chk("d6_active_rdy", req_rdy, 1);

        // randomized traffic
        flush_cnt = 0;
        for (int c = 0; c < 4000; c++) begin
            drive_edge();
            rst_n          = ($urandom_range(0, 499) != 0);
            req_vld        = ($urandom_range(0, 9) < 7);
            req_addr       = 8'h10 + 8'($urandom_range(0, 7));
            req_data       = {$urandom(), $urandom(), $urandom(), $urandom()};
            req_start_byte = 4'($urandom());
            req_end_byte   = 4'($urandom());
            ent_free       = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom());
            ent_addr_match = ($urandom_range(0, 3) == 0) ? 8'($urandom()) : 8'h00;
            rel_vld        = ($urandom_range(0, 3) == 0);
            rel_idx        = 3'($urandom());
            if (flush_cnt > 0) begin
                flush_req = 1'b1;
                flush_cnt--;
            end else begin
                flush_req = 1'b0;
                if ($urandom_range(0, 59) == 0) flush_cnt = $urandom_range(1, 6);
            end
        end
        drive_edge();
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
